abc_input_conditioner: RTL
==========================

ABC_INPUT_CONDITIONER -- requirements
Module: abc_input_conditioner

Interface
REQ-001 Parameter: DEB_CYCLES, default 4, is the number of consecutive differing synchronized samples required to accept a level change; the legal range is 1..255.
REQ-002 Port: clk, input, 1 bit, is the rising-edge system clock.
REQ-003 Port: reset, input, 1 bit, is the reset; it SHALL be asynchronous and active-high.
REQ-004 Port: a_raw, b_raw and c_raw, input, 1 bit each, are asynchronous raw switch/button levels that may bounce.
REQ-005 Port: a, b and c, output, 1 bit each, are the debounced levels that drive the downstream a/b/c-qualified state machine.
REQ-006 Port: all_rise, output, 1 bit, is a one-cycle pulse marking a 0->1 transition of (a & b & c).
REQ-007 Port: glitch_cnt, output, 8 bits, is a saturating count of rejected bounces summed over all channels.

Function
REQ-008 Each raw input SHALL pass through a 2-flop synchronizer before any other logic; the second flop is the channel's "synced" value.
REQ-009 Each channel SHALL hold a stable-level register that drives its output (a, b or c) and a run counter 8 bits wide.
REQ-010 On each clock edge where synced != stable and the run counter + 1 < DEB_CYCLES, the run counter SHALL increment.
REQ-011 On the clock edge where synced != stable and the run counter + 1 == DEB_CYCLES, stable SHALL take the synced value and the run counter SHALL clear to 0.
REQ-012 On a clock edge where synced == stable and the run counter != 0, the run counter SHALL clear to 0 and that channel SHALL count as one rejected bounce.
REQ-013 On a clock edge where synced == stable and the run counter == 0, the channel SHALL hold.
REQ-014 Latency: a raw level held steady SHALL appear on the output exactly DEB_CYCLES+2 rising edges after the first edge that samples it.
REQ-015 With DEB_CYCLES=1, an output SHALL change 3 edges after the raw change, and no bounce is ever rejected.
REQ-016 glitch_cnt SHALL add the number of channels rejecting on that edge (0..3) and SHALL saturate at 255, never wrapping.
REQ-017 all_rise SHALL be a registered output that is 1 for exactly one cycle, in the cycle following the edge on which (a & b & c) went 0->1; it is 0 otherwise.
REQ-018 all_rise SHALL NOT re-assert while (a & b & c) remains 1; a fresh pulse requires (a & b & c) to fall and rise again.
REQ-019 Channels SHALL be fully independent: simultaneous changes on several inputs are each debounced on their own counters.
REQ-020 If the final channel completing a&b&c and another channel falling resolve on the same edge, all_rise SHALL reflect the resulting (a & b & c) value only.

Reset
REQ-021 While reset is 1, all synchronizer flops, stable registers, run counters, glitch_cnt and all_rise SHALL be 0, asynchronously and without waiting for clk.
REQ-022 Outputs a, b and c SHALL be 0 during and immediately after reset.
REQ-023 Assertion of reset mid-debounce SHALL discard the partial count; after release, debouncing SHALL restart from stable=0.
REQ-024 Inputs that are high at reset release SHALL produce a 0->1 output transition DEB_CYCLES+2 edges after release, and all_rise SHALL fire if all three inputs are high.

Verification
REQ-025 Scenario: DEB_CYCLES=4, with a_raw going 0->1 and held -> a=1 exactly 6 edges later, with glitch_cnt=0.
REQ-026 Scenario: DEB_CYCLES=4, with b_raw pulsed high for 2 cycles then low -> b stays 0, and glitch_cnt increments by 1 once the pulse has propagated.
REQ-027 Scenario: a_raw, b_raw and c_raw rising on different cycles and all held -> a single one-cycle all_rise after the last channel's output rises, with no repeat while the inputs are held.
REQ-028 Scenario: all three raw inputs each bouncing 1-cycle pulses simultaneously -> glitch_cnt increments by 3 on the same edge; a 100-bounce run -> glitch_cnt holds at 255.
REQ-029 Scenario: reset asserted between edges while a run counter is at 3 -> all outputs 0 immediately; after release with a_raw=1, a=1 6 edges later.
REQ-030 Scenario: with a=b=c=1, c_raw dropping for 4+ cycles then returning -> c falls then rises, and exactly one new all_rise pulse occurs on the re-rise.

Source files
------------

// File: rtl/abc_input_conditioner.sv
// Three-channel synchronizer and debouncer for the a/b/c qualifier inputs, with a
// registered pulse on the rise of (a & b & c) and a saturating rejected-bounce count.
module abc_input_conditioner #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    input  logic       c_raw,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       all_rise,
    output logic [7:0] glitch_cnt
);
    // Nine bits so that run+1 never wraps when DEB_CYCLES is 255.
    localparam logic [8:0] DEB_LIM = 9'(DEB_CYCLES);

    logic [2:0]      raw;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      stable_q;
    logic [2:0]      stable_d;
    logic [2:0][7:0] run_q;
    logic [2:0][7:0] run_d;
    logic [2:0]      reject;
    logic [7:0]      glitch_q;
    logic [7:0]      glitch_d;
    logic            all_rise_q;
    logic            all_rise_d;

    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign raw = {c_raw, b_raw, a_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // A run of differing samples either completes (level accepted) or is broken
    // early by an agreeing sample, which is what counts as a rejected bounce.
    always_comb begin
        stable_d = stable_q;
        run_d    = run_q;
        reject   = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (({1'b0, run_q[i]} + 9'd1) == DEB_LIM) begin
                    stable_d[i] = sync2_q[i];
                    run_d[i]    = '0;
                end else begin
                    run_d[i] = run_q[i] + 8'd1;
                end
            end else if (run_q[i] != 8'd0) begin
                run_d[i]  = '0;
                reject[i] = 1'b1;
            end
        end
    end

    // The pulse is taken from next-state levels so it lines up with the first
    // cycle in which a, b and c are all high.
    always_comb begin
        glitch_d   = sat_add8(glitch_q, count_ones3(reject));
        all_rise_d = (&stable_d) & ~(&stable_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q   <= '0;
            run_q      <= '0;
            glitch_q   <= '0;
            all_rise_q <= 1'b0;
        end else begin
            stable_q   <= stable_d;
            run_q      <= run_d;
            glitch_q   <= glitch_d;
            all_rise_q <= all_rise_d;
        end
    end

    assign a          = stable_q[0];
    assign b          = stable_q[1];
    assign c          = stable_q[2];
    assign all_rise   = all_rise_q;
    assign glitch_cnt = glitch_q;

endmodule
